// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types, constants and helpers for the score display
// Contents: converter state type, SEG_BLANK, seg7 decode, points lookup, max_score.
package score_pkg;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_LOAD
  } conv_state_t;

  // Active-low segments, bit 0 = segment a.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Zero means the event carries no score and is ignored.
  function automatic logic [3:0] points(input logic [2:0] lines);
    logic [3:0] p;
    case (lines)
      3'd1:    p = 4'd1;
      3'd2:    p = 4'd3;
      3'd3:    p = 4'd5;
      3'd4:    p = 4'd8;
      default: p = 4'd0;
    endcase
    return p;
  endfunction

  function automatic int unsigned max_score(input int digits);
    int unsigned r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/score_bcd_display_if.sv
// rtl/score_bcd_display_if.sv - game-logic to score display signal bundle
// master: game logic (drives clear, line_valid, lines_cleared, game_over)
// slave : score display (drives score, busy, hex)
interface score_bcd_display_if #(
  parameter int NUM_DIGITS = 6,
  parameter int SCORE_W    = 20
);
  logic                       clear;
  logic                       line_valid;
  logic [2:0]                 lines_cleared;
  logic                       game_over;
  logic [SCORE_W-1:0]         score;
  logic                       busy;
  logic [NUM_DIGITS-1:0][6:0] hex;

  modport master (
    output clear, line_valid, lines_cleared, game_over,
    input  score, busy, hex
  );

  modport slave (
    input  clear, line_valid, lines_cleared, game_over,
    output score, busy, hex
  );
endinterface

// File: rtl/score_bcd_display_bin2bcd.sv
// rtl/score_bcd_display_bin2bcd.sv - sequential double-dabble binary to BCD converter
// Ports: clk, reset_n (async, active-low), start (accepted in IDLE), bin (value
// captured on start), busy (not IDLE), done (LOAD cycle), bcd (working digits, final during done).
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int SCORE_W    = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [SCORE_W-1:0]      bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(SCORE_W + 1);

  conv_state_t        state, state_nx;
  logic [SCORE_W-1:0] sh;
  logic [BW-1:0]      work, work_adj;
  logic [CW-1:0]      cnt;

  // Add-3 correction on every nibble that would overflow a decimal digit when doubled.
  always_comb begin
    work_adj = work;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      CONV_IDLE:  if (start) state_nx = CONV_SHIFT;
      CONV_SHIFT: if (cnt == CW'(SCORE_W - 1)) state_nx = CONV_LOAD;
      CONV_LOAD:  state_nx = CONV_IDLE;
      default:    state_nx = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= CONV_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh   <= '0;
      work <= '0;
      cnt  <= '0;
    end else if (state == CONV_IDLE && start) begin
      sh   <= bin;
      work <= '0;
      cnt  <= '0;
    end else if (state == CONV_SHIFT) begin
      work <= {work_adj[BW-2:0], sh[SCORE_W-1]};
      sh   <= {sh[SCORE_W-2:0], 1'b0};
      cnt  <= cnt + 1'b1;
    end
  end

  assign busy = (state != CONV_IDLE);
  assign done = (state == CONV_LOAD);
  assign bcd  = work;
endmodule

// File: rtl/score_bcd_display.sv
// rtl/score_bcd_display.sv - Tetris score accumulator with BCD seven-segment display
// Ports: clk, reset_n (async, active-low), bus (slave): clear, line_valid,
// lines_cleared, game_over in; score, busy, hex (active-low, digit 0 = LSD) out.
module score_bcd_display
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCORE_W    = 20,
  parameter int BLANK_LZ   = 1,
  parameter int BLINK_DIV  = 25000000
) (
  input logic                clk,
  input logic                reset_n,
  score_bcd_display_if.slave bus
);
  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(max_score(NUM_DIGITS));
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Event inputs are registered once; the score follows one cycle later.
  logic       ev_valid, ev_clear;
  logic [3:0] ev_points;

  logic [SCORE_W-1:0]      score_q, score_nx;
  logic [SCORE_W:0]        sum;
  logic                    dirty;
  logic                    conv_start, conv_busy, conv_done;
  logic [4*NUM_DIGITS-1:0] conv_bcd, disp;
  logic [BCW-1:0]          blink_cnt;
  logic                    blink_on;
  logic                    lz_run;
  logic [NUM_DIGITS-1:0][6:0] hex_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_valid  <= 1'b0;
      ev_clear  <= 1'b0;
      ev_points <= '0;
    end else begin
      ev_valid  <= bus.line_valid && (points(bus.lines_cleared) != 4'd0);
      ev_clear  <= bus.clear;
      ev_points <= points(bus.lines_cleared);
    end
  end

  // Saturating add; clear wins over a simultaneous event.
  always_comb begin
    sum      = {1'b0, score_q} + (SCORE_W + 1)'(ev_points);
    score_nx = score_q;
    if (ev_clear)      score_nx = '0;
    else if (ev_valid) score_nx = (sum > {1'b0, MAX_SCORE}) ? MAX_SCORE : sum[SCORE_W-1:0];
  end

  // A conversion is only started from IDLE, so a mid-conversion update leaves
  // dirty set and re-triggers once the running conversion has been displayed.
  assign conv_start = dirty && !conv_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_q <= '0;
      dirty   <= 1'b0;
    end else begin
      score_q <= score_nx;
      if (ev_clear || (score_nx != score_q)) dirty <= 1'b1;
      else if (conv_start)                   dirty <= 1'b0;
    end
  end

  bin2bcd_seq #(
    .SCORE_W    (SCORE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (conv_start),
    .bin     (score_q),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  // Display only changes on a finished conversion, so it is never torn.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       disp <= '0;
    else if (conv_done) disp <= conv_bcd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!bus.game_over) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Walk from the most significant digit down; lz_run stays set while every
  // digit seen so far is zero. Digit 0 is never blanked by this rule.
  always_comb begin
    lz_run = 1'b1;
    hex_nx = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run && (disp[4*k +: 4] == 4'd0);
      if (!blink_on || ((BLANK_LZ != 0) && (k != 0) && lz_run)) hex_nx[k] = SEG_BLANK;
      else                                                      hex_nx[k] = seg7(disp[4*k +: 4]);
    end
  end

  assign bus.score = score_q;
  assign bus.busy  = conv_busy || dirty;
  assign bus.hex   = hex_nx;
endmodule

// File: doc/score_bcd_display.md
Name: score_bcd_display

Overview:
- Parametrised successor to the per-bit line indicator: accumulates a Tetris score from line-clear events and converts it to decimal with a sequential double-dabble engine.
- Drives NUM_DIGITS active-low seven-segment digits (DE1-SoC HEX0..HEXn), with optional leading-zero blanking and game-over blink.
- Sits between the game-logic FSM (line-clear events, game_over) and the board HEX pins.

Parameters:
- NUM_DIGITS, 6, number of decimal digits displayed; score saturates at 10^NUM_DIGITS-1.
- SCORE_W, 20, binary score width; must satisfy 2^SCORE_W > 10^NUM_DIGITS-1.
- BLANK_LZ, 1, 1 = blank leading zeros (digit 0 always lit); 0 = show all zeros.
- BLINK_DIV, 25000000, clk cycles per blink half-period while game_over is high.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous score clear (new game).
- line_valid  in  1  one-cycle strobe: a line-clear event is present.
- lines_cleared  in  3  lines removed by the event (valid values 1..4).
- game_over  in  1  level; enables blinking.
- score  out  SCORE_W  current binary score (registered).
- busy  out  1  converter active or a restart is pending.
- hex  out  NUM_DIGITS x 7  segment outputs, active-low (bit 0 = segment a); digit 0 is least significant.

Behaviour:
- Reset (reset_n low, asynchronous):
  - score = 0; BCD shift and display registers = 0; busy = 0; pending = 0.
  - Blink counter = 0; blink phase = on.
  - hex: digit 0 shows "0" (7'b1000000). Other digits are blank (7'b1111111) if BLANK_LZ, else "0".
- Points table, indexed by lines_cleared: 1 -> 1, 2 -> 3, 3 -> 5, 4 -> 8. Values 0 and 5..7 -> ignored (no score change, no conversion).
- Score update (registered):
  - On a valid event the score at the next edge is min(score + points, 10^NUM_DIGITS-1). Saturation is sticky; there is no wrap-around.
  - clear has priority over line_valid in the same cycle: score becomes 0.
  - Every score change, or any clear, sets the dirty flag. A clear sets dirty even when the score is already 0.
- Converter FSM, states IDLE, SHIFT, LOAD:
  - IDLE: if dirty, capture score into the shift register, zero the BCD digits, clear dirty, go to SHIFT.
  - SHIFT: exactly SCORE_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left 1 with the next binary MSB in.
  - LOAD: copy the BCD nibbles into the display register in one cycle. Go to IDLE; dirty re-triggers there immediately.
  - busy = (state != IDLE) || dirty.
  - If an event arrives mid-conversion, the current conversion completes on the old captured value, then a new one runs. The display is never torn.
- Latency: with the converter idle, line_valid sampled at edge t gives:
  - score valid after edge t+1;
  - hex valid after edge t+SCORE_W+3.
- Leading-zero blank (BLANK_LZ=1): digit k>0 is blank if it and all higher digits are 0.
- Blink:
  - When game_over is high, the counter runs 0..BLINK_DIV-1 and the phase toggles at wrap. When the phase is off, all digits are blank.
  - When game_over is low, the counter is held at 0 and the phase is on.
  - Score updates continue during game_over.
- Digit decode: 0-9 use standard active-low patterns. Nibbles 10-15 are unreachable and decode to blank.

Decomposition:
- score_pkg:
  - SEG_BLANK constant;
  - seg7 decode function (nibble -> active-low segments);
  - points lookup function;
  - max-score function of NUM_DIGITS.
- Sub-module bin2bcd_seq (params SCORE_W, NUM_DIGITS; ports clk, reset_n, start, bin, busy, done, bcd). Top-level instantiates it plus the score, blink and decode logic.

Test Plan:
- Reset then idle -> score=0, busy=0, hex[0]=7'b1000000, hex[5:1]=7'b1111111.
- line_valid with lines_cleared=4 at edge t -> score=8 after t+1, busy high, hex[0]=7'b0000000 ("8") after edge t+23, higher digits blank.
- Events of 4,4,3 lines spaced 3 cycles apart (mid-conversion) -> final score=21, busy stays high until the second conversion ends. hex shows "21"; no intermediate value other than "8" or "21" ever appears.
- Preload near max (repeated 4-line events) to 999995, then a 4-line event -> score=999999, hex all "9". A further event leaves it unchanged.
- clear and line_valid (4 lines) in the same cycle at score=13 -> score=0, display returns to "0".
- BLINK_DIV=4, game_over=1 with score 21 -> hex alternates blank and "21" every 4 cycles. Drop game_over -> steady "21" next cycle. Assert reset_n low mid-SHIFT -> all state at reset values immediately.
